codecracker_multi_timer: RTL and testbench
==========================================

// Module: codecracker_multi_timer
// PURPOSE
//  NUM_CH independent interval timers behind one 16-bit Avalon-MM slave, with a shared IRQ.
//  Successor to the single-channel interval timer. Adds configurable counter width, a per-channel
//  clock prescaler and a read-only IRQ-pending summary word. Sits on the system interconnect as a
//  memory-mapped peripheral, with irq wired to the CPU interrupt controller.
// PARAMETERS
//  NUM_CH        4      number of channels, 1..8
//  CNT_W         32     counter/period width, 17..32; read/written as two 16-bit halves
//  RESET_PERIOD  49999  reset value of every channel's period and counter
// PORTS
//  clk         in   1                 system clock; the only clock
//  reset_n     in   1                 asynchronous active-low reset
//  address     in   3+clog2(NUM_CH)   word address: {channel, reg[2:0]}
//  chipselect  in   1                 slave select
//  write_n     in   1                 active-low write strobe, valid with chipselect
//  writedata   in   16                write data
//  readdata    out  16                registered read data, 1-cycle latency
//  irq         out  1                 OR of all channel interrupts
// BEHAVIOUR
//  Register map per channel (reg):
//   0 STATUS   {RUN,TO}; any write clears TO
//   1 CONTROL  [0]ITO [1]CONT [2]START(wo) [3]STOP(wo); bits 1:0 stored, reads return {00,CONT,ITO}
//   2 PERL     period low half
//   3 PERH     period high half; bits >= CNT_W read 0
//   4 SNAPL    low half; any write to 4 or 5 captures the live counter
//   5 SNAPH    high half
//   6 PRESC    16-bit prescale divisor minus 1; 0 = tick every clk
//   7 IRQPEND  read-only {.., irq_ch[NUM_CH-1:0]}, same value in every channel's slot 7
//  Writes use the Avalon write timing: chipselect & ~write_n, acting on the rising edge.
//  Unmapped or out-of-range channels read 0, and writes to them are ignored.
//  Per-channel prescaler pcnt:
//   - Advances only while RUN.
//   - tick = (pcnt == PRESC); pcnt wraps to 0 on tick.
//   - pcnt clears on START, on a period write and on a PRESC write.
//  Counter:
//   - On a RUN & tick with cnt != 0: cnt <= cnt - 1.
//   - On a RUN & tick with cnt == 0: this is a timeout event. cnt <= period, TO <= 1;
//     if CONT = 0 then RUN <= 0.
//   - Timeout therefore recurs every (period+1)*(PRESC+1) clks.
//   - A write to PERL or PERH sets force_reload for the next cycle. That cycle does
//     cnt <= {PERH,PERL} and RUN <= 0.
//   - START in that same cycle still sets RUN.
//  START and STOP in the same write: START wins and RUN = 1.
//  A timeout event in the same cycle as a STATUS write: set wins, so TO = 1 and no event is lost.
//  irq_ch[i] = TO[i] & ITO[i]; irq = |irq_ch. irq is combinational from registered state, with
//  no extra latency after TO sets.
//  The period is unsigned CNT_W bits. period = 0 gives a timeout every PRESC+1 clks while running.
//  The snapshot holds the full CNT_W bits and stays stable until the next snapshot write.
//  Reset (asynchronous, any time, including mid-count):
//   - readdata = 0, irq = 0, RUN = 0, TO = 0, CONTROL = 0
//   - period = cnt = RESET_PERIOD, PRESC = 0, pcnt = 0, snapshot = 0
//   - nothing counts until START.
//  readdata updates every cycle from the address mux, whether or not chipselect is asserted.
// TESTING
//  1. Reset, then read ch0 regs 2/3 -> 0xC34F/0x0000; STATUS = 0; irq = 0.
//  2. ch1: PERL = 9, PERH = 0, CONTROL = 0x7 (START|CONT|ITO) -> TO and irq every 10 clks;
//     STATUS write clears irq; it re-asserts 10 clks after the previous timeout.
//  3. ch2: PERL = 4, PRESC = 2, CONTROL = 0x4 (one-shot) -> one timeout at 15 clks after START;
//     then RUN = 0 and cnt = 4 held.
//  4. ch0 running with period 100: write snapshot at cnt = 57, then read SNAPL/SNAPH
//     -> 57/0; a later read is unchanged.
//  5. Simultaneous events: STATUS write on the timeout cycle -> TO = 1;
//     CONTROL = 0xC -> RUN = 1; PERL write while running -> RUN = 0, cnt = new period.
//  6. NUM_CH = 4: timeouts on ch1 and ch3 -> IRQPEND = 0x000A; assert reset_n low
//     mid-count -> irq = 0 and all registers at reset values the same cycle.

Source files
------------

// File: rtl/codecracker_multi_timer_if.sv
// Bus bundle for the multi-channel interval timer.
// Carries the Avalon-MM slave signals and the shared interrupt line.
interface codecracker_multi_timer_if #(
    parameter int NUM_CH = 4
) ();
    localparam int ADDR_W = 3 + $clog2(NUM_CH);

    // Handshake: a write happens on the rising edge where chipselect = 1 and
    // write_n = 0. There is no wait state. readdata is registered. It reflects
    // the address presented on the previous edge, whether or not chipselect is
    // asserted. irq is a level that stays high while any enabled timeout is pending.
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;
    logic              irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/codecracker_multi_timer.sv
// NUM_CH independent down-counting interval timers with per-channel prescaler.
// The timers share one 16-bit register window and one OR-ed interrupt line.
// Address = {channel, reg[2:0]}. Counter and period are CNT_W bits wide and are
// accessed as two 16-bit halves.
module codecracker_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                       clk,
    input  logic                       reset_n,
    codecracker_multi_timer_if.slave   bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AX_W = 3 + CH_W;
    localparam logic [CNT_W-1:0] RST_PER = CNT_W'(RESET_PERIOD);

    // Address decode. The address is widened so a single-channel build still has a channel field.
    logic [AX_W-1:0] addr_x;
    logic [CH_W-1:0] sel_ch;
    logic [2:0]      sel_reg;
    logic            wr_en;

    assign addr_x  = AX_W'(bus.address);
    assign sel_ch  = addr_x[AX_W-1:3];
    assign sel_reg = addr_x[2:0];
    assign wr_en   = bus.chipselect & ~bus.write_n;

    // Per-channel state
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] to;
    logic [NUM_CH-1:0] ito;
    logic [NUM_CH-1:0] cont;
    logic [NUM_CH-1:0] force_reload;
    logic [CNT_W-1:0]  period [NUM_CH];
    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [CNT_W-1:0]  snap   [NUM_CH];
    logic [15:0]       presc  [NUM_CH];
    logic [15:0]       pcnt   [NUM_CH];

    // Per-channel strobes and events
    logic [NUM_CH-1:0] wr_status;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_perl;
    logic [NUM_CH-1:0] wr_perh;
    logic [NUM_CH-1:0] wr_snap;
    logic [NUM_CH-1:0] wr_presc;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] tmo;
    logic [NUM_CH-1:0] irq_ch;

    logic [15:0] rd_next;
    logic [15:0] readdata_q;

    // Decode a bus write into one strobe per channel and register. Channels that are out of range match nothing.
    always_comb begin
        wr_status = '0;
        wr_ctrl   = '0;
        wr_perl   = '0;
        wr_perh   = '0;
        wr_snap   = '0;
        wr_presc  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && (int'(sel_ch) == i)) begin
                case (sel_reg)
                    3'd0:       wr_status[i] = 1'b1;
                    3'd1:       wr_ctrl[i]   = 1'b1;
                    3'd2:       wr_perl[i]   = 1'b1;
                    3'd3:       wr_perh[i]   = 1'b1;
                    3'd4, 3'd5: wr_snap[i]   = 1'b1;
                    3'd6:       wr_presc[i]  = 1'b1;
                    default:    ;
                endcase
            end
        end
    end

    assign start = wr_ctrl & {NUM_CH{bus.writedata[2]}};
    assign stop  = wr_ctrl & {NUM_CH{bus.writedata[3]}};

    // Prescaler tick and timeout event. A forced reload cycle does not count.
    always_comb begin
        tick = '0;
        tmo  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tick[i] = run[i] && !force_reload[i] && (pcnt[i] == presc[i]);
            tmo[i]  = tick[i] && (cnt[i] == '0);
        end
    end

    // Per-channel timer state: configuration, prescaler, counter, run/timeout flags and snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run          <= '0;
            to           <= '0;
            ito          <= '0;
            cont         <= '0;
            force_reload <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period[i] <= RST_PER;
                cnt[i]    <= RST_PER;
                snap[i]   <= '0;
                presc[i]  <= '0;
                pcnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ctrl[i]) begin
                    ito[i]  <= bus.writedata[0];
                    cont[i] <= bus.writedata[1];
                end

                if (wr_perl[i]) begin
                    period[i][15:0] <= bus.writedata;
                end
                if (wr_perh[i]) begin
                    period[i][CNT_W-1:16] <= bus.writedata[CNT_W-17:0];
                end
                force_reload[i] <= wr_perl[i] | wr_perh[i];

                if (wr_presc[i]) begin
                    presc[i] <= bus.writedata;
                end

                // The prescaler restarts whenever timing parameters change or the channel starts.
                if (start[i] || wr_perl[i] || wr_perh[i] || wr_presc[i]) begin
                    pcnt[i] <= '0;
                end else if (tick[i]) begin
                    pcnt[i] <= '0;
                end else if (run[i]) begin
                    pcnt[i] <= pcnt[i] + 16'd1;
                end

                // The counter reloads after a period write, or on the tick after it reaches zero.
                if (force_reload[i]) begin
                    cnt[i] <= period[i];
                end else if (tmo[i]) begin
                    cnt[i] <= period[i];
                end else if (tick[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end

                // START outranks every condition that stops the channel.
                if (start[i]) begin
                    run[i] <= 1'b1;
                end else if (stop[i] || force_reload[i] || (tmo[i] && !cont[i])) begin
                    run[i] <= 1'b0;
                end

                // A timeout that coincides with a clear still sets the flag, so the event is not lost.
                if (tmo[i]) begin
                    to[i] <= 1'b1;
                end else if (wr_status[i]) begin
                    to[i] <= 1'b0;
                end

                if (wr_snap[i]) begin
                    snap[i] <= cnt[i];
                end
            end
        end
    end

    assign irq_ch  = to & ito;
    assign bus.irq = |irq_ch;

    // Read mux. Unknown channels return zero. Slot 7 of every channel shows the pending summary.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(sel_ch) == i) begin
                case (sel_reg)
                    3'd0:    rd_next = {14'd0, run[i], to[i]};
                    3'd1:    rd_next = {14'd0, cont[i], ito[i]};
                    3'd2:    rd_next = period[i][15:0];
                    3'd3:    rd_next = 16'(period[i] >> 16);
                    3'd4:    rd_next = snap[i][15:0];
                    3'd5:    rd_next = 16'(snap[i] >> 16);
                    3'd6:    rd_next = presc[i];
                    default: rd_next = 16'(irq_ch);
                endcase
            end
        end
    end

    // Registered read data, which updates every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= rd_next;
        end
    end

    assign bus.readdata = readdata_q;
endmodule

// File: tb/tb_codecracker_multi_timer.sv
// Self-checking bench for codecracker_multi_timer (NUM_CH = 4, CNT_W = 32).
module tb_codecracker_multi_timer;
    localparam int NUM_CH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   t_to    = 0;
    logic [15:0] exp_q[$];

    codecracker_multi_timer_if #(.NUM_CH(NUM_CH)) bus_if ();

    codecracker_multi_timer #(
        .NUM_CH(NUM_CH),
        .CNT_W(32),
        .RESET_PERIOD(49999)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_if)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks. Each one starts and ends at a falling edge and uses exactly one rising edge.
    task automatic wr(input int ch, input int r, input logic [15:0] d);
        bus_if.address    = 5'(ch * 8 + r);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic rd(input int ch, input int r, output logic [15:0] d);
        bus_if.address    = 5'(ch * 8 + r);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        @(negedge clk);
        d = bus_if.readdata;
        bus_if.chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] v, e;
        int regs[3];
        regs = '{2, 3, 0};
        bus_if.address = '0; bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.writedata = '0;
        reset_n = 1'b0;
        idle(3);
        checks++;
        if (bus_if.readdata !== 16'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0000", bus_if.readdata); end
        checks++;
        if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus_if.irq); end
        reset_n = 1'b1;
        idle(1);
        exp_q.push_back(16'hC34F);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 3; i++) begin
            rd(0, regs[i], v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin errors++; $display("FAIL reset_reg%0d: got %h expected %h", regs[i], v, e); end
        end
    endtask

    task automatic test_continuous();
        int t_start, t_first, n;
        wr(1, 2, 16'd9);
        wr(1, 3, 16'd0);
        wr(1, 1, 16'h0007);
        t_start = cyc;
        n = 0;
        while (bus_if.irq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (cyc - t_start != 10) begin errors++; $display("FAIL cont_first_timeout: got %0d clks expected 10", cyc - t_start); end
        t_first = cyc;
        wr(1, 0, 16'h0000);
        checks++;
        if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL cont_status_clear: irq got %b expected 0", bus_if.irq); end
        n = 0;
        while (bus_if.irq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (cyc - t_first != 10) begin errors++; $display("FAIL cont_reassert: got %0d clks expected 10", cyc - t_first); end
        t_to = cyc;
    endtask

    task automatic test_one_shot();
        logic [15:0] v, e;
        int t_start, n;
        wr(2, 2, 16'd4);
        wr(2, 6, 16'd2);
        wr(2, 1, 16'h0004);
        t_start = cyc;
        v = '0;
        n = 0;
        while (v[0] !== 1'b1 && n < 100) begin rd(2, 0, v); n++; end
        checks++;
        if (cyc - t_start - 1 != 15) begin errors++; $display("FAIL oneshot_latency: got %0d clks expected 15", cyc - t_start - 1); end
        exp_q.push_back(16'h0001);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin errors++; $display("FAIL oneshot_status: got %h expected %h", v, e); end
        idle(20);
        wr(2, 4, 16'h0);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0000);
        for (int r = 4; r < 6; r++) begin
            rd(2, r, v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin errors++; $display("FAIL oneshot_hold_snap%0d: got %h expected %h", r, v, e); end
        end
    endtask

    task automatic test_snapshot();
        logic [15:0] v, e;
        int regs[4];
        regs = '{4, 5, 1, 4};
        wr(0, 2, 16'd100);
        wr(0, 3, 16'd0);
        wr(0, 1, 16'h0006);
        idle(43);
        wr(0, 5, 16'h0);
        exp_q.push_back(16'd57);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'd57);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) idle(30);
            rd(0, regs[i], v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin errors++; $display("FAIL snapshot_step%0d: got %h expected %h", i, v, e); end
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] v, e;
        int w;
        w = (t_to - (cyc + 1)) % 10;
        if (w < 0) w += 10;
        idle(w);
        wr(1, 0, 16'h0);
        checks++;
        if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL sim_status_on_timeout: irq got %b expected 1", bus_if.irq); end
        wr(1, 0, 16'h0);
        checks++;
        if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL sim_status_off_timeout: irq got %b expected 0", bus_if.irq); end

        wr(2, 1, 16'h000C);
        exp_q.push_back(16'h0003);
        rd(2, 0, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin errors++; $display("FAIL sim_start_stop: got %h expected %h", v, e); end

        wr(2, 2, 16'd7);
        idle(1);
        exp_q.push_back(16'h0001);
        rd(2, 0, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin errors++; $display("FAIL sim_perl_stops: got %h expected %h", v, e); end
        wr(2, 4, 16'h0);
        exp_q.push_back(16'd7);
        rd(2, 4, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin errors++; $display("FAIL sim_perl_reload: got %h expected %h", v, e); end
    endtask

    task automatic test_irqpend_reset();
        logic [15:0] v, e;
        int chs[6];
        int regs[6];
        wr(3, 2, 16'd2);
        wr(3, 3, 16'd0);
        wr(3, 1, 16'h0007);
        idle(20);
        exp_q.push_back(16'h000A);
        exp_q.push_back(16'h000A);
        rd(0, 7, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin errors++; $display("FAIL irqpend_ch0: got %h expected %h", v, e); end
        rd(3, 7, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin errors++; $display("FAIL irqpend_ch3: got %h expected %h", v, e); end
        checks++;
        if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL irq_shared: got %b expected 1", bus_if.irq); end

        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b expected 0", bus_if.irq); end
        checks++;
        if (bus_if.readdata !== 16'h0) begin errors++; $display("FAIL async_reset_readdata: got %h expected 0000", bus_if.readdata); end
        @(negedge clk);
        reset_n = 1'b1;
        idle(5);
        wr(1, 4, 16'h0);
        chs  = '{1, 1, 3, 0, 2, 1};
        regs = '{2, 0, 1, 4, 6, 4};
        exp_q.push_back(16'hC34F);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hC34F);
        for (int i = 0; i < 6; i++) begin
            rd(chs[i], regs[i], v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin errors++; $display("FAIL post_reset_ch%0d_reg%0d: got %h expected %h", chs[i], regs[i], v, e); end
        end
        checks++;
        if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b expected 0", bus_if.irq); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_continuous();
        test_one_shot();
        test_snapshot();
        test_simultaneous();
        test_irqpend_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
